program_sequencer: RTL

Program-counter and run-control sequencer for the 9-bit single-cycle core.
- Owns the PC, the start/done handshake to the bench or host, stall hold, branch redirection and halt detection.
- Gates register-file and data-memory write enables, so nothing commits outside RUN.
- Sits between the top-level control inputs and the instruction ROM, decoder and ALU.

---
 rtl/program_sequencer_pkg.sv | 13 +
 rtl/program_sequencer_pc_next_sel.sv | 25 ++
 rtl/program_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared types and constants for the program sequencer and the core decoder.
package seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

   typedef enum logic [1:0] {SEL_HOLD, SEL_INC, SEL_TARGET, SEL_START} pc_sel_t;

   localparam int PC_W_DEF = 10;

   // Opcode field value the decoder recognises as halt.
   localparam logic [2:0] OP_HALT = 3'b111;

endpackage

// File: rtl/program_sequencer_pc_next_sel.sv
// Combinational next-PC mux: hold, increment with wrap, branch target, or run start.
module pc_next_sel
   import seq_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0] START_PC = '0
) (
   input  pc_sel_t         sel,
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] target,
   output logic [PC_W-1:0] pc_next
);

   always_comb begin
      pc_next = pc;
      case (sel)
         SEL_HOLD:   pc_next = pc;
         SEL_INC:    pc_next = pc + PC_W'(1);
         SEL_TARGET: pc_next = target;
         SEL_START:  pc_next = START_PC;
         default:    pc_next = pc;
      endcase
   end

endmodule

// File: rtl/program_sequencer.sv
// PC and run-control sequencer: start/done handshake, stall hold, branch, halt.
// Optional RUN-cycle watchdog enabled by defining PROGRAM_SEQUENCER_WATCHDOG_EN.
module program_sequencer
   import seq_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0] START_PC = '0,
   parameter int              CNT_W    = 16,
   parameter int              WDOG_CYC = 4096
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Stall,
   input  logic             Halt_req,
   input  logic             Branch_en,
   input  logic             Branch_cond,
   input  logic [PC_W-1:0]  Target,
   output logic [PC_W-1:0]  PC,
   output logic             Exec_en,
   output logic             Done,
   output logic             Timeout,
   output logic [CNT_W-1:0] Instr_cnt
);

   seq_state_t      state;
   pc_sel_t         pc_sel;
   logic [PC_W-1:0] pc_next;
   logic            wd_hit;

`ifdef PROGRAM_SEQUENCER_WATCHDOG_EN
   logic [CNT_W-1:0] wdog_cnt;

   // Fires on the WDOG_CYC-th RUN cycle, stalled cycles included.
   assign wd_hit = (state == RUN) && (wdog_cnt == CNT_W'(WDOG_CYC - 1));

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         wdog_cnt <= '0;
      else if (state == IDLE && Start)
         wdog_cnt <= '0;
      else if (state == RUN)
         wdog_cnt <= wdog_cnt + 1'b1;
   end
`else
   assign wd_hit = 1'b0;
`endif

   assign Exec_en = (state == RUN) && !Stall && !wd_hit;

   always_comb begin
      pc_sel = SEL_HOLD;
      case (state)
         IDLE: if (Start) pc_sel = SEL_START;
         RUN:
            if (Exec_en && !Halt_req)
               pc_sel = (Branch_en && Branch_cond) ? SEL_TARGET : SEL_INC;
         default: pc_sel = SEL_HOLD;
      endcase
   end

   pc_next_sel #(
      .PC_W    (PC_W),
      .START_PC(START_PC)
   ) u_pc_next_sel (
      .sel    (pc_sel),
      .pc     (PC),
      .target (Target),
      .pc_next(pc_next)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         PC        <= START_PC;
         Done      <= 1'b0;
         Timeout   <= 1'b0;
         Instr_cnt <= '0;
      end else begin
         PC <= pc_next;
         case (state)
            IDLE: begin
               if (Start) begin
                  state     <= RUN;
                  Instr_cnt <= '0;
                  Timeout   <= 1'b0;
               end
            end
            RUN: begin
               if (wd_hit) begin
                  state   <= DONE;
                  Done    <= 1'b1;
                  Timeout <= 1'b1;
               end else if (!Stall) begin
                  if (Instr_cnt != '1)
                     Instr_cnt <= Instr_cnt + 1'b1;
                  if (Halt_req) begin
                     state <= DONE;
                     Done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (!Start) begin
                  state <= IDLE;
                  Done  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
